// File: rtl/module_seg_scan.sv
// Binary-to-BCD multiplexed 7-segment driver: accepts a value over valid/ready,
// converts it with a sequential shift-add-3 engine and scans DIGITS common-anode digits.
module module_seg_scan #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 2,
  parameter int SCAN_DIV       = 13500,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  bin_i,
  input  logic              bin_valid_i,
  output logic              bin_ready_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o,
  output logic              overflow_o
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(WIDTH);
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

  // Segment order is {g,f,e,d,c,b,a}, active-high before polarity is applied.
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LATCH
  } state_e;

  state_e              state_q,    state_d;
  logic [WIDTH-1:0]    shift_q,    shift_d;
  logic [BCD_W-1:0]    bcd_q,      bcd_d;
  logic [ITER_W-1:0]   iter_q,     iter_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]    disp_q,     disp_d;
  logic                ovf_q,      ovf_d;
  logic [PRE_W-1:0]    presc_q,    presc_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Conversion FSM and datapath.
  always_comb begin
    logic [3:0] adj;
    logic       carry;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    adj        = '0;
    carry      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bin_valid_i) begin
          shift_d    = bin_i;
          bcd_d      = '0;
          iter_d     = '0;
          ovf_pend_d = (32'(bin_i) > MAX_VAL);
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        // Adjust each nibble, then shift {bcd, shift} left; the top nibble's carry is dropped.
        carry = shift_q[WIDTH-1];
        for (int i = 0; i < DIGITS; i++) begin
          adj                  = add3(bcd_q[4*i +: 4]);
          bcd_d[4*i+1 +: 3]    = adj[2:0];
          bcd_d[4*i]           = carry;
          carry                = adj[3];
        end
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        iter_d  = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(WIDTH - 1)) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit scan prescaler and index.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  // Output decode, driven purely from registers.
  always_comb begin
    logic [DIGITS-1:0] blank;
    logic              upper_zero;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [6:0]        seg_raw;

    blank      = '0;
    upper_zero = 1'b1;
    cur_nib    = '0;
    cur_blank  = 1'b0;
    an_o       = '0;

    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      blank[i]   = (LZ_BLANK != 0) && upper_zero;
    end

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_o[i]   = 1'b1;
        cur_nib   = disp_q[4*i +: 4];
        cur_blank = blank[i];
      end
    end

    if (ovf_q)          seg_raw = SEG_DASH;
    else if (cur_blank) seg_raw = SEG_BLANK;
    else                seg_raw = glyph(cur_nib);

    seg_o = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  end

  assign bin_ready_o = (state_q == ST_IDLE);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_module_seg_scan.sv
// Directed bench for module_seg_scan: four instances share one input stream to
// cover leading-zero blanking, 3-digit scan timing and the single-digit case.
module tb_module_seg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] bin;
  logic       valid;

  logic       rdy_a, ovf_a, rdy_b, ovf_b, rdy_c, ovf_c, rdy_d, ovf_d;
  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic [1:0] an_a, an_b;
  logic [2:0] an_c;
  logic [0:0] an_d;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  module_seg_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bin_i(bin), .bin_valid_i(valid), .bin_ready_o(rdy_a),
    .seg_o(seg_a), .an_o(an_a), .overflow_o(ovf_a));

  module_seg_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(0), .SEG_ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bin_i(bin), .bin_valid_i(valid), .bin_ready_o(rdy_b),
    .seg_o(seg_b), .an_o(an_b), .overflow_o(ovf_b));

  module_seg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bin_i(bin), .bin_valid_i(valid), .bin_ready_o(rdy_c),
    .seg_o(seg_c), .an_o(an_c), .overflow_o(ovf_c));

  module_seg_scan #(.WIDTH(8), .DIGITS(1), .SCAN_DIV(4), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1)) u_d (
    .clk(clk), .rst_n(rst_n), .bin_i(bin), .bin_valid_i(valid), .bin_ready_o(rdy_d),
    .seg_o(seg_d), .an_o(an_d), .overflow_o(ovf_d));

  // Active-low glyphs {g,f,e,d,c,b,a}
  localparam logic [6:0] G0    = 7'b1000000;
  localparam logic [6:0] G2    = 7'b0100100;
  localparam logic [6:0] G4    = 7'b0011001;
  localparam logic [6:0] G7    = 7'b1111000;
  localparam logic [6:0] G9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  // Waits (bounded) for digit d of the chosen instance to be enabled and samples seg_o.
  task automatic sample_digit(input int dut, input int d, output logic [6:0] seg, output bit ok);
    ok  = 1'b0;
    seg = 'x;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      case (dut)
        0: if (an_a == 2'(1 << d)) begin seg = seg_a; ok = 1'b1; end
        1: if (an_b == 2'(1 << d)) begin seg = seg_b; ok = 1'b1; end
        2: if (an_c == 3'(1 << d)) begin seg = seg_c; ok = 1'b1; end
        default: begin seg = seg_d; ok = 1'b1; end
      endcase
    end
  endtask

  // Accepts v, then counts sampled cycles with ready low; returns overflow seen on the last low sample.
  task automatic do_accept(input logic [7:0] v, output int low_cnt, output logic ovf_last_low);
    @(negedge clk);
    bin   = v;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid        = 1'b0;
    low_cnt      = 0;
    ovf_last_low = ovf_a;
    while (rdy_a === 1'b0 && low_cnt < 40) begin
      low_cnt++;
      ovf_last_low = ovf_a;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bin   = '0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy_a); else pass_cnt++;
    chk_cnt++; if (an_a !== 2'b01) $display("FAIL reset_an got %b want 01", an_a); else pass_cnt++;
    chk_cnt++; if (seg_a !== G0) $display("FAIL reset_seg got %b want %b", seg_a, G0); else pass_cnt++;
    chk_cnt++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf_a); else pass_cnt++;
    chk_cnt++; if (an_c !== 3'b001) $display("FAIL reset_an_c got %b want 001", an_c); else pass_cnt++;
    chk_cnt++; if (an_d !== 1'b1) $display("FAIL reset_an_d got %b want 1", an_d); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_convert_42();
    int low; logic ovl; logic [6:0] s; bit ok;
    do_accept(8'd42, low, ovl);
    chk_cnt++; if (low != 9) $display("FAIL c42_busy_cycles got %0d want 9", low); else pass_cnt++;
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL c42_ready_back got %b want 1", rdy_a); else pass_cnt++;
    chk_cnt++; if (ovf_a !== 1'b0) $display("FAIL c42_ovf got %b want 0", ovf_a); else pass_cnt++;
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== G4) $display("FAIL c42_digit1 got %b want %b", s, G4); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== G2) $display("FAIL c42_digit0 got %b want %b", s, G2); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int low; logic ovl; logic [6:0] s; bit ok;
    do_accept(8'd100, low, ovl);
    chk_cnt++; if (low != 9) $display("FAIL c100_busy_cycles got %0d want 9", low); else pass_cnt++;
    chk_cnt++; if (ovl !== 1'b0) $display("FAIL c100_ovf_early got %b want 0", ovl); else pass_cnt++;
    chk_cnt++; if (ovf_a !== 1'b1) $display("FAIL c100_ovf got %b want 1", ovf_a); else pass_cnt++;
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== DASH) $display("FAIL c100_digit1 got %b want %b", s, DASH); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== DASH) $display("FAIL c100_digit0 got %b want %b", s, DASH); else pass_cnt++;
    // Back-to-back accept at the earliest legal edge.
    do_accept(8'd99, low, ovl);
    chk_cnt++; if (low != 9) $display("FAIL c99_busy_cycles got %0d want 9", low); else pass_cnt++;
    chk_cnt++; if (ovf_a !== 1'b0) $display("FAIL c99_ovf got %b want 0", ovf_a); else pass_cnt++;
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== G9) $display("FAIL c99_digit1 got %b want %b", s, G9); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== G9) $display("FAIL c99_digit0 got %b want %b", s, G9); else pass_cnt++;
  endtask

  task automatic test_leading_zero();
    int low; logic ovl; logic [6:0] s; bit ok;
    do_accept(8'd7, low, ovl);
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== BLANK) $display("FAIL lz_a_digit1 got %b want %b", s, BLANK); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== G7) $display("FAIL lz_a_digit0 got %b want %b", s, G7); else pass_cnt++;
    sample_digit(1, 1, s, ok);
    chk_cnt++; if (!ok || s !== G0) $display("FAIL nolz_b_digit1 got %b want %b", s, G0); else pass_cnt++;
    sample_digit(1, 0, s, ok);
    chk_cnt++; if (!ok || s !== G7) $display("FAIL nolz_b_digit0 got %b want %b", s, G7); else pass_cnt++;
    sample_digit(2, 2, s, ok);
    chk_cnt++; if (!ok || s !== BLANK) $display("FAIL lz_c_digit2 got %b want %b", s, BLANK); else pass_cnt++;
    sample_digit(3, 0, s, ok);
    chk_cnt++; if (!ok || s !== G7) $display("FAIL d1_digit0 got %b want %b", s, G7); else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [2:0] seq [4];
    int cnt, bad;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    cnt = 0;
    while (an_c !== 3'b100 && cnt < 40) begin cnt++; @(negedge clk); end
    cnt = 0;
    while (an_c !== 3'b001 && cnt < 40) begin cnt++; @(negedge clk); end
    for (int s = 0; s < 3; s++) begin
      cnt = 0;
      while (an_c === seq[s] && cnt < 10) begin cnt++; @(negedge clk); end
      chk_cnt++;
      if (cnt != 4) $display("FAIL scan_hold_%0d an=%b held %0d want 4", s, seq[s], cnt);
      else pass_cnt++;
    end
    chk_cnt++; if (an_c !== seq[3]) $display("FAIL scan_wrap got %b want %b", an_c, seq[3]); else pass_cnt++;
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      if (an_d !== 1'b1) bad++;
      @(negedge clk);
    end
    chk_cnt++; if (bad != 0) $display("FAIL d1_an_fixed got %0d bad samples want 0", bad); else pass_cnt++;
  endtask

  task automatic test_busy();
    logic [6:0] s; bit ok; int cnt;
    @(negedge clk);
    bin   = 8'd42;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    bin   = 8'd55;
    valid = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rdy_a !== 1'b0) $display("FAIL busy_ready got %b want 0", rdy_a); else pass_cnt++;
    @(negedge clk);
    valid = 1'b0;
    cnt = 0;
    while (rdy_a !== 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    repeat (2) @(negedge clk);
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL busy_idle got %b want 1", rdy_a); else pass_cnt++;
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== G4) $display("FAIL busy_digit1 got %b want %b", s, G4); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== G2) $display("FAIL busy_digit0 got %b want %b", s, G2); else pass_cnt++;
  endtask

  task automatic test_reset_mid_conv();
    logic [6:0] s; bit ok;
    @(negedge clk);
    bin   = 8'd99;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL rstmid_ready got %b want 1", rdy_a); else pass_cnt++;
    chk_cnt++; if (an_a !== 2'b01) $display("FAIL rstmid_an got %b want 01", an_a); else pass_cnt++;
    chk_cnt++; if (seg_a !== G0) $display("FAIL rstmid_seg got %b want %b", seg_a, G0); else pass_cnt++;
    chk_cnt++; if (ovf_a !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", ovf_a); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_cnt++; if (rdy_a !== 1'b1) $display("FAIL rstmid_idle got %b want 1", rdy_a); else pass_cnt++;
    sample_digit(0, 1, s, ok);
    chk_cnt++; if (!ok || s !== BLANK) $display("FAIL rstmid_digit1 got %b want %b", s, BLANK); else pass_cnt++;
    sample_digit(0, 0, s, ok);
    chk_cnt++; if (!ok || s !== G0) $display("FAIL rstmid_digit0 got %b want %b", s, G0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_convert_42();
    test_overflow();
    test_leading_zero();
    test_scan();
    test_busy();
    test_reset_mid_conv();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/module_seg_scan.md
# module_seg_scan

Parametrised binary-to-decimal multiplexed 7-segment display driver: the next generation of the two-digit segment subsystem. A binary value is accepted over a valid/ready handshake. It is converted to BCD by a sequential shift-add-3 engine and latched into display registers. DIGITS common-anode digits are then time-multiplexed from a single segment bus. The block sits between the input decode/LED subsystem and the board's 7-segment pins.

## Interface
- WIDTH, 8: binary input width, 4..16.
- DIGITS, 2: number of displayed decimal digits, 1..4.
- SCAN_DIV, 13500: clk cycles each digit stays enabled; at least 2.
- LZ_BLANK, 1: 1 blanks leading zeros; 0 shows all digits.
- SEG_ACTIVE_LOW, 1: 1 drives seg_o inverted (lit = 0).

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- bin_i  in  WIDTH  unsigned value to display; sampled on accept.
- bin_valid_i  in  1  bin_i is valid.
- bin_ready_o  out  1  block can accept a value (high only in IDLE).
- seg_o  out  7  {g,f,e,d,c,b,a} for the currently enabled digit.
- an_o  out  DIGITS  one-hot digit enable, active-high; bit 0 is the least significant digit.
- overflow_o  out  1  last latched value exceeds 10^DIGITS-1.

## Operation
- Accept: bin_valid_i && bin_ready_o sampled high at a rising edge.
  - bin_i is copied to the shift register.
  - The BCD register (4*DIGITS bits) is cleared.
  - ovf_pending = (bin_i > 10^DIGITS-1).
  - State goes IDLE -> CONV.
- FSM states:
  - IDLE: ready = 1.
  - CONV: runs exactly WIDTH iterations, one per cycle, counted by an iteration counter.
    - Each iteration: every BCD nibble >= 5 gets +3, then {bcd, shift} shifts left by 1.
    - Bits shifted out of the top BCD nibble are discarded; overflow covers that case.
    - After iteration WIDTH the state goes to LATCH.
  - LATCH: display registers <= BCD, overflow_o <= ovf_pending, then -> IDLE.
- bin_valid_i outside IDLE is ignored. Values are not queued, and bin_i changes during CONV have no effect.
- Glyph mapping:
  - Standard glyphs for 0-9.
  - 1 = b,c.
  - 7 = a,b,c.
  - 6 includes a; 9 includes d.
- Overflow: when overflow_o = 1, every digit shows a dash (g only). Blanking does not apply.
- Leading-zero blanking (LZ_BLANK = 1):
  - Digit i > 0 shows all segments off when it and every higher digit are 0.
  - Digit 0 is never blanked.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On terminal count the prescaler returns to 0 and the digit index advances.
  - The digit index wraps from DIGITS-1 to 0.
  - an_o = 1 << index; seg_o = glyph of display digit[index].
- Polarity: SEG_ACTIVE_LOW inverts seg_o only. an_o polarity is fixed.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - state = IDLE, bin_ready_o = 1.
  - Display registers = 0, overflow_o = 0.
  - Prescaler = 0, digit index = 0, an_o = 1 (digit 0).
  - seg_o = glyph "0": a-f lit, g off, with SEG_ACTIVE_LOW applied.
- Accept at edge k:
  - bin_ready_o is low from edge k until edge k+WIDTH+1.
  - CONV iterations occur on edges k+1..k+WIDTH.
  - Display registers and overflow_o update on edge k+WIDTH+1.
  - bin_ready_o is high again after edge k+WIDTH+1, so the next accept is at edge k+WIDTH+2 at the earliest.
- seg_o and an_o are registered or decoded from registers only, with no combinational path from bin_i.
- A display update mid-scan takes effect on the next clock. The scan position is not disturbed.
- rst_n asserted mid-CONV aborts the conversion: no partial value is latched, and all outputs take their reset values.
- With DIGITS = 1, the digit index stays 0 and an_o stays 1.

## Test plan
- Reset (WIDTH=8, DIGITS=2, SEG_ACTIVE_LOW=1):
  - Hold rst_n low -> bin_ready_o=1, an_o=01, seg_o=7'b1000000, overflow_o=0.
- Convert 42:
  - Accept at edge k -> bin_ready_o low for 9 edges.
  - Display becomes {4,2} at edge k+9; overflow_o=0.
- Convert 100:
  - Display shows dashes on both digits (seg_o=7'b0111111 active-low).
  - overflow_o=1.
  - A following accept of 99 clears overflow_o and shows {9,9}.
- Leading zeros, convert 7:
  - LZ_BLANK=1: digit 1 seg_o=7'b1111111, digit 0 shows "7".
  - LZ_BLANK=0: digit 1 shows "0".
- Scan with SCAN_DIV=4, DIGITS=3:
  - an_o sequence 001,010,100,001, each held exactly 4 cycles.
- Busy and reset mid-conversion:
  - Pulse bin_valid_i with 55 during CONV -> ignored; 42 is still displayed.
  - Assert rst_n low at edge k+3 -> display returns to 0 and bin_ready_o=1 immediately.
